// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: baud tick generation, byte serialiser, and 16x
// oversampling receiver with a sticky ready flag and holding register.
module uart_top #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_enb,
    input  logic [7:0] data_in,
    output logic       tx_active,
    output logic       tx_serial_out,
    input  logic       rx_serial_in,
    input  logic       rdy_clr,
    output logic [7:0] rx_data_out,
    output logic       rx_ready
);
    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TXW    = $clog2(TX_DIV + 1);
    localparam int RXW    = $clog2(RX_DIV + 1);
    localparam int SW     = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} st_t;

    // ---------------- RX oversample tick (free running) ----------------
    logic [RXW-1:0] r_rx_div;
    logic           w_rx_tick;

    assign w_rx_tick = (r_rx_div == RXW'(RX_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_rx_div <= '0;
        else if (w_rx_tick) r_rx_div <= '0;
        else                r_rx_div <= r_rx_div + RXW'(1);
    end

    // ---------------- TX ----------------
    st_t            r_tx_st, w_tx_st_nxt;
    logic [TXW-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]     r_tx_bit, w_tx_bit_nxt;
    logic [7:0]     r_tx_byte, w_tx_byte_nxt;
    logic           w_tx_tick;
    logic           w_tx_out;

    assign w_tx_tick = (r_tx_cnt == TXW'(TX_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_st   <= ST_IDLE;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_byte <= '0;
        end else begin
            r_tx_st   <= w_tx_st_nxt;
            r_tx_cnt  <= w_tx_cnt_nxt;
            r_tx_bit  <= w_tx_bit_nxt;
            r_tx_byte <= w_tx_byte_nxt;
        end
    end

    // The bit-time counter is held at zero in IDLE so every frame starts a full bit period.
    always_comb begin
        w_tx_st_nxt   = r_tx_st;
        w_tx_cnt_nxt  = w_tx_tick ? '0 : r_tx_cnt + TXW'(1);
        w_tx_bit_nxt  = r_tx_bit;
        w_tx_byte_nxt = r_tx_byte;
        w_tx_out      = 1'b1;
        case (r_tx_st)
            ST_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (wr_enb) begin
                    w_tx_byte_nxt = data_in;
                    w_tx_st_nxt   = ST_START;
                end
            end
            ST_START: begin
                w_tx_out = 1'b0;
                if (w_tx_tick) begin
                    w_tx_st_nxt  = ST_DATA;
                    w_tx_bit_nxt = '0;
                end
            end
            ST_DATA: begin
                w_tx_out = r_tx_byte[r_tx_bit];
                if (w_tx_tick) begin
                    if (r_tx_bit == 3'd7) w_tx_st_nxt  = ST_STOP;
                    else                  w_tx_bit_nxt = r_tx_bit + 3'd1;
                end
            end
            ST_STOP: begin
                if (w_tx_tick) w_tx_st_nxt = ST_IDLE;
            end
            default: w_tx_st_nxt = ST_IDLE;
        endcase
    end

    assign tx_active     = (r_tx_st != ST_IDLE);
    assign tx_serial_out = w_tx_out;

    // ---------------- RX ----------------
    logic          r_rx_meta, r_rx_sync;
    st_t           r_rx_st, w_rx_st_nxt;
    logic [SW-1:0] r_rx_scnt, w_rx_scnt_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    r_rx_sh, w_rx_sh_nxt;
    logic [7:0]    r_rx_data, w_rx_data_nxt;
    logic          r_rx_rdy, w_rx_rdy_nxt;
    logic          w_rx_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_st   <= ST_IDLE;
            r_rx_scnt <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_rx_rdy  <= 1'b0;
        end else begin
            r_rx_meta <= rx_serial_in;
            r_rx_sync <= r_rx_meta;
            r_rx_st   <= w_rx_st_nxt;
            r_rx_scnt <= w_rx_scnt_nxt;
            r_rx_bit  <= w_rx_bit_nxt;
            r_rx_sh   <= w_rx_sh_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_rx_rdy  <= w_rx_rdy_nxt;
        end
    end

    always_comb begin
        w_rx_st_nxt   = r_rx_st;
        w_rx_scnt_nxt = r_rx_scnt;
        w_rx_bit_nxt  = r_rx_bit;
        w_rx_sh_nxt   = r_rx_sh;
        w_rx_data_nxt = r_rx_data;
        w_rx_load     = 1'b0;
        case (r_rx_st)
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_st_nxt   = ST_START;
                    w_rx_scnt_nxt = '0;
                end
            end
            ST_START: begin
                if (w_rx_tick) begin
                    if (r_rx_scnt == SW'(OVERSAMPLE / 2 - 1)) begin
                        w_rx_scnt_nxt = '0;
                        w_rx_bit_nxt  = '0;
                        w_rx_st_nxt   = r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        w_rx_scnt_nxt = r_rx_scnt + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_tick) begin
                    if (r_rx_scnt == SW'(OVERSAMPLE - 1)) begin
                        w_rx_scnt_nxt = '0;
                        w_rx_sh_nxt   = {r_rx_sync, r_rx_sh[7:1]};
                        if (r_rx_bit == 3'd7) w_rx_st_nxt  = ST_STOP;
                        else                  w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end else begin
                        w_rx_scnt_nxt = r_rx_scnt + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_rx_tick) begin
                    if (r_rx_scnt == SW'(OVERSAMPLE - 1)) begin
                        w_rx_scnt_nxt = '0;
                        w_rx_st_nxt   = ST_IDLE;
                        // A low stop bit is a framing error: the byte is dropped.
                        if (r_rx_sync) begin
                            w_rx_data_nxt = r_rx_sh;
                            w_rx_load     = 1'b1;
                        end
                    end else begin
                        w_rx_scnt_nxt = r_rx_scnt + SW'(1);
                    end
                end
            end
            default: w_rx_st_nxt = ST_IDLE;
        endcase
        w_rx_rdy_nxt = w_rx_load ? 1'b1 : (rdy_clr ? 1'b0 : r_rx_rdy);
    end

    assign rx_data_out = r_rx_data;
    assign rx_ready    = r_rx_rdy;

endmodule

// File: tb/tb_uart_top.sv
// Loopback and direct-drive bench for uart_top; expected line bits and
// received bytes come from a frame-level model of the 8N1 format.
module tb_uart_top;
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;
    localparam int BIT    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_enb = 1'b0;
    logic       rdy_clr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       loop_en = 1'b1;
    logic       rx_drv = 1'b1;
    logic       tx_active, tx_serial_out, rx_ready, rx_in;
    logic [7:0] rx_data_out;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_data = 8'h00;

    assign rx_in = loop_en ? tx_serial_out : rx_drv;

    always #10 clk = ~clk;

    uart_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .wr_enb(wr_enb), .data_in(data_in),
        .tx_active(tx_active), .tx_serial_out(tx_serial_out),
        .rx_serial_in(rx_in), .rdy_clr(rdy_clr),
        .rx_data_out(rx_data_out), .rx_ready(rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Line level during bit slot k of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic clr_rdy();
        @(negedge clk) rdy_clr = 1'b1;
        @(negedge clk) rdy_clr = 1'b0;
        chk("rdy_clr", rx_ready, 0);
        chk("rdy_clr_data", rx_data_out, m_data);
    endtask

    task automatic xfer(input logic [7:0] b, input bit busy, input logic [7:0] bb);
        int act, rises, rise_at;
        logic prev;
        @(negedge clk) begin data_in = b; wr_enb = 1'b1; end
        @(negedge clk) begin wr_enb = 1'b0; data_in = ~b; end
        act = 0; rises = 0; rise_at = -1; prev = rx_ready;
        for (int n = 0; n < 11 * BIT; n++) begin
            if (n > 0) @(negedge clk);
            if (busy && n == 3 * BIT)     begin wr_enb = 1'b1; data_in = bb; end
            if (busy && n == 3 * BIT + 1) wr_enb = 1'b0;
            if (tx_active) act++;
            if (n % BIT == BIT / 2 && n / BIT < 10)
                chk($sformatf("txbit%0d_%02h", n / BIT, b), tx_serial_out, frame_bit(b, n / BIT));
            if (rx_ready && !prev) begin
                rises++;
                if (rise_at < 0) rise_at = n;
            end
            prev = rx_ready;
        end
        m_data = b;
        chk("tx_active_len", act, 10 * BIT);
        chk("rdy_rises", rises, 1);
        chk("rdy_latency", (rise_at > 9 * BIT) && (rise_at < 11 * BIT), 1);
        chk("rx_data", rx_data_out, m_data);
        chk("rx_ready", rx_ready, 1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge clk) rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BIT) @(negedge clk);
        end
        // A bad stop bit stays low past the sample point only, so the trailing
        // low reads as a glitch rather than a new start bit.
        rx_drv = stop_ok;
        if (!stop_ok) repeat (300) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    initial begin
        logic [7:0] r, r2;
        int lows, acts;
        #50;
        chk("rst_tx_out", tx_serial_out, 1);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rx_data", rx_data_out, 8'h00);
        #50 reset = 1'b1;
        repeat (5) @(negedge clk);

        xfer(8'hA5, 1'b0, 8'h00);
        clr_rdy();
        xfer(8'h00, 1'b0, 8'h00);
        clr_rdy();
        xfer(8'hFF, 1'b0, 8'h00);
        clr_rdy();

        // Second write mid-frame must be dropped entirely.
        xfer(8'h3C, 1'b1, 8'hC3);
        lows = 0; acts = 0;
        for (int n = 0; n < 2 * BIT; n++) begin
            @(negedge clk);
            if (!tx_serial_out) lows++;
            if (tx_active) acts++;
        end
        chk("busy_no_2nd_frame", lows + acts, 0);
        chk("busy_data_kept", rx_data_out, 8'h3C);

        // Reset mid-frame while rx_ready is still set from the last byte.
        @(negedge clk) begin data_in = 8'h96; wr_enb = 1'b1; end
        @(negedge clk) wr_enb = 1'b0;
        repeat (3 * BIT + 50) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_tx_out", tx_serial_out, 1);
        chk("midrst_tx_active", tx_active, 0);
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_rx_data", rx_data_out, 8'h00);
        m_data = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("midrst_no_partial", rx_ready, 0);
        xfer(8'h5A, 1'b0, 8'h00);
        clr_rdy();

        for (int i = 0; i < 3; i++) begin
            xfer(8'($urandom_range(0, 255)), 1'b0, 8'h00);
            clr_rdy();
        end

        // Direct RX drive: glitch, good frame, framing error.
        loop_en = 1'b0;
        @(negedge clk) rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_no_rdy", rx_ready, 0);
        chk("glitch_data", rx_data_out, m_data);

        r = 8'($urandom_range(0, 255));
        drive_frame(r, 1'b1);
        m_data = r;
        chk("direct_rdy", rx_ready, 1);
        chk("direct_data", rx_data_out, m_data);
        clr_rdy();

        r2 = r ^ 8'($urandom_range(1, 255));
        drive_frame(r2, 1'b0);
        chk("frmerr_rdy", rx_ready, 0);
        chk("frmerr_data", rx_data_out, m_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_top.md
Name: uart_top

Overview:
- Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first.
- Contains a shared baud-tick generator, a transmitter that serialises a byte on a write strobe, and a 16x-oversampling receiver that deserialises into a sticky-ready holding register.
- Sits between a simple parallel host interface and the serial pins. The top-level bench ties tx_serial_out to rx_serial_in for loopback.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, receiver samples per bit.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_enb  input  1  one-cycle strobe requesting transmission of data_in.
- data_in  input  8  byte to transmit, captured on the wr_enb cycle.
- tx_active  output  1  high while a frame is being transmitted.
- tx_serial_out  output  1  serial TX line, idle high.
- rx_serial_in  input  1  serial RX line, asynchronous to clk, idle high.
- rdy_clr  input  1  one-cycle strobe that clears rx_ready.
- rx_data_out  output  8  last correctly received byte.
- rx_ready  output  1  sticky flag: a new byte is available.

Behaviour:
- Reset values (applied asynchronously when reset=0): tx_serial_out=1, tx_active=0, rx_ready=0, rx_data_out=8'h00. All FSMs go to IDLE and the tick counters clear.
- Reset mid-frame aborts TX and RX immediately. The line returns high and no partial byte is delivered.

Baud generation:
- TX tick: one-cycle pulse every CLK_HZ/BAUD clocks (434 at default).
- RX tick: one-cycle pulse every CLK_HZ/(BAUD*OVERSAMPLE) clocks (27 at default). Integer division truncates.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: tx_serial_out=1, tx_active=0.
- wr_enb=1 in IDLE: latch data_in, set tx_active=1 on the next edge, enter START, and restart the TX tick counter.
- START: drive 0 for one bit time.
- DATA: drive bits 0..7, LSB first, one bit time each.
- STOP: drive 1 for one bit time, then return to IDLE and drop tx_active.
- wr_enb while tx_active=1 is ignored. The latched byte is not altered by data_in changes mid-frame.
- A frame lasts exactly 10 bit times (10*CLK_HZ/BAUD clocks).

RX input conditioning:
- rx_serial_in passes through a 2-flop synchroniser before any use.

RX FSM (IDLE, START, DATA, STOP):
- IDLE: on a synchronised low, enter START and clear the sample counter.
- START: after OVERSAMPLE/2 RX ticks (mid-bit), re-sample.
  - Low: enter DATA.
  - High: treat as a glitch and return to IDLE.
- DATA: every OVERSAMPLE RX ticks, sample one bit into a shift register, LSB first. After 8 bits, enter STOP.
- STOP: after OVERSAMPLE RX ticks, sample the line.
  - 1: load rx_data_out with the shifted byte and set rx_ready=1.
  - 0 (framing error): discard the byte; rx_data_out and rx_ready are unchanged.
  - Either way, return to IDLE.
- rx_ready stays high until a rdy_clr=1 cycle, which clears it on the next edge.
- rdy_clr in the same cycle as a new-byte load: set wins, so rx_ready=1.
- A new byte arriving while rx_ready=1 overwrites rx_data_out; rx_ready stays 1.
- rx_data_out holds its value between frames.

Loopback latency:
- rx_ready rises about 9.5 bit times after tx_serial_out falls for the start bit.
- It must rise before tx_active falls plus 1 bit time.

Test Plan:
- Loopback, default params: reset=0 for 100 ns, release, pulse wr_enb for 1 cycle with data_in=8'hA5.
  - Required: tx_active=1 for 10 bit times.
  - tx_serial_out sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop).
  - rx_ready rises and rx_data_out=8'hA5.
- rdy_clr: after the 8'hA5 receive, pulse rdy_clr.
  - Required: rx_ready=0 on the next edge; rx_data_out stays 8'hA5.
- Boundary bytes: loop back 8'h00 then 8'hFF (clear ready between them).
  - Required: each is received exactly, with rx_ready set once per byte.
- Busy write: pulse wr_enb with 8'h3C, then pulse wr_enb with 8'hC3 mid-frame.
  - Required: only 8'h3C is transmitted and received; no second frame follows.
- Reset mid-frame: assert reset=0 during DATA.
  - Required: tx_serial_out=1, tx_active=0, rx_ready=0 immediately.
  - After release, a fresh 8'h5A transfer succeeds.
- RX errors: drive rx_serial_in directly.
  - A low pulse shorter than half a bit gives no rx_ready.
  - A frame with stop bit=0 gives rx_ready unchanged and rx_data_out unchanged.
